// File: rtl/axi4_lite_write_slave_responder_if.sv
// AXI4-Lite write-channel bundle (AW, W, B) shared by the write master agent
// and the slave responder.
interface axi4_lite_write_slave_responder_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic                      awvalid;
    logic                      awready;
    logic [ADDRESS_WIDTH-1:0]  awaddr;
    logic [2:0]                awprot;
    logic                      wvalid;
    logic                      wready;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   wstrb;
    logic                      bvalid;
    logic                      bready;
    logic [1:0]                bresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        input  awready, wready, bvalid, bresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        output awready, wready, bvalid, bresp
    );
endinterface

// File: rtl/axi4_lite_write_slave_responder.sv
// AXI4-Lite write responder: one outstanding write, programmable ready and
// response delays, address decode, strobed word memory with a debug read port.
module axi4_lite_write_slave_responder #(
    parameter int                        ADDRESS_WIDTH = 32,
    parameter int                        DATA_WIDTH    = 32,
    parameter int                        DELAY_WIDTH   = 5,
    parameter logic [ADDRESS_WIDTH-1:0]  MIN_ADDRESS   = 'h01,
    parameter logic [ADDRESS_WIDTH-1:0]  MAX_ADDRESS   = 'hff,
    parameter int                        MEM_DEPTH     = 64
) (
    input  logic                           aclk,
    input  logic                           areset,
    axi4_lite_write_slave_responder_if.slave bus,
    input  logic [DELAY_WIDTH-1:0]         cfgAwreadyDelay,
    input  logic [DELAY_WIDTH-1:0]         cfgWreadyDelay,
    input  logic [DELAY_WIDTH-1:0]         cfgBvalidDelay,
    input  logic [$clog2(MEM_DEPTH)-1:0]   dbgRdAddr,
    output logic [DATA_WIDTH-1:0]          dbgRdData
);
    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam int STRB_W = DATA_WIDTH / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {IDLE, WRITE, BDELAY, RESP} state_t;

    state_t                   state;
    logic                     aw_full;
    logic                     w_full;
    logic [ADDRESS_WIDTH-1:0] aw_addr;
    logic [2:0]               prot_unused;
    logic [DATA_WIDTH-1:0]    w_data;
    logic [STRB_W-1:0]        w_strb;
    logic [DELAY_WIDTH-1:0]   aw_cnt;
    logic [DELAY_WIDTH-1:0]   w_cnt;
    logic [DELAY_WIDTH-1:0]   b_cnt;
    logic                     bvalid_q;
    logic [1:0]               bresp_q;
    logic [DATA_WIDTH-1:0]    mem [MEM_DEPTH];

    logic aw_ready;
    logic w_ready;
    logic aw_hs;
    logic w_hs;
    logic [1:0] wr_resp;

    // Out-of-range takes priority over misalignment.
    function automatic logic [1:0] decode_resp(input logic [ADDRESS_WIDTH-1:0] addr);
        if (addr < MIN_ADDRESS || addr > MAX_ADDRESS) return RESP_DECERR;
        if (addr[1:0] != 2'b00)                       return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] merge_strb(input logic [DATA_WIDTH-1:0] old,
                                                         input logic [DATA_WIDTH-1:0] data,
                                                         input logic [STRB_W-1:0]     strb);
        logic [DATA_WIDTH-1:0] r;
        r = old;
        for (int i = 0; i < STRB_W; i++)
            if (strb[i]) r[8*i +: 8] = data[8*i +: 8];
        return r;
    endfunction

    assign aw_ready = !areset && bus.awvalid && !aw_full && (aw_cnt >= cfgAwreadyDelay);
    assign w_ready  = !areset && bus.wvalid  && !w_full  && (w_cnt  >= cfgWreadyDelay);
    assign aw_hs    = aw_ready;
    assign w_hs     = w_ready;
    assign wr_resp  = decode_resp(aw_addr);

    assign bus.awready = aw_ready;
    assign bus.wready  = w_ready;
    assign bus.bvalid  = bvalid_q;
    assign bus.bresp   = bresp_q;
    assign dbgRdData   = mem[dbgRdAddr];

    always_ff @(posedge aclk) begin
        if (areset) begin
            state       <= IDLE;
            aw_full     <= 1'b0;
            w_full      <= 1'b0;
            aw_addr     <= '0;
            prot_unused <= '0;
            w_data      <= '0;
            w_strb      <= '0;
            aw_cnt      <= '0;
            w_cnt       <= '0;
            b_cnt       <= '0;
            bvalid_q    <= 1'b0;
            bresp_q     <= RESP_OKAY;
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
        end else begin
            // Ready-delay counters only run while a valid is waiting on an empty slot.
            if (aw_hs)
                aw_cnt <= '0;
            else if (bus.awvalid && !aw_full && aw_cnt != '1)
                aw_cnt <= aw_cnt + DELAY_WIDTH'(1);
            if (w_hs)
                w_cnt <= '0;
            else if (bus.wvalid && !w_full && w_cnt != '1)
                w_cnt <= w_cnt + DELAY_WIDTH'(1);

            if (aw_hs) begin
                aw_full     <= 1'b1;
                aw_addr     <= bus.awaddr;
                prot_unused <= bus.awprot;
            end
            if (w_hs) begin
                w_full <= 1'b1;
                w_data <= bus.wdata;
                w_strb <= bus.wstrb;
            end

            case (state)
                IDLE: begin
                    if ((aw_full || aw_hs) && (w_full || w_hs)) state <= WRITE;
                end
                WRITE: begin
                    bresp_q <= wr_resp;
                    if (wr_resp == RESP_OKAY)
                        mem[aw_addr[2 +: IDX_W]] <= merge_strb(mem[aw_addr[2 +: IDX_W]], w_data, w_strb);
                    if (cfgBvalidDelay == '0) begin
                        bvalid_q <= 1'b1;
                        state    <= RESP;
                    end else begin
                        b_cnt <= cfgBvalidDelay;
                        state <= BDELAY;
                    end
                end
                BDELAY: begin
                    b_cnt <= b_cnt - DELAY_WIDTH'(1);
                    if (b_cnt == DELAY_WIDTH'(1)) begin
                        bvalid_q <= 1'b1;
                        state    <= RESP;
                    end
                end
                RESP: begin
                    if (bus.bready) begin
                        bvalid_q <= 1'b0;
                        aw_full  <= 1'b0;
                        w_full   <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi4_lite_write_slave_responder.sv
// Randomized bench for the AXI4-Lite write responder against a word-array
// reference model with latency and response expectations from the protocol rules.
module tb_axi4_lite_write_slave_responder;
    logic        aclk = 1'b0;
    logic        areset;
    logic [4:0]  cfg_aw, cfg_w, cfg_b;
    logic [5:0]  dbg_addr;
    logic [31:0] dbg_data;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] mem_model [64];
    logic [31:0] nxt_addr, nxt_data;
    logic [3:0]  nxt_strb;

    axi4_lite_write_slave_responder_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axi4_lite_write_slave_responder dut (
        .aclk            (aclk),
        .areset          (areset),
        .bus             (bus),
        .cfgAwreadyDelay (cfg_aw),
        .cfgWreadyDelay  (cfg_w),
        .cfgBvalidDelay  (cfg_b),
        .dbgRdAddr       (dbg_addr),
        .dbgRdData       (dbg_data)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] model_resp(input logic [31:0] a);
        if (a < 32'h1 || a > 32'hff) return 2'b11;
        if (a % 4 != 0)              return 2'b10;
        return 2'b00;
    endfunction

    function automatic int model_idx(input logic [31:0] a);
        return int'((a / 4) % 64);
    endfunction

    task automatic idle_bus();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.awaddr  = '0;   bus.awprot = '0;   bus.wdata  = '0; bus.wstrb = '0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 64; i++) mem_model[i] = '0;
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < 64; i++) begin
            dbg_addr = 6'(i);
            #1;
            check(tag, dbg_data, mem_model[i]);
        end
    endtask

    // One complete write; block_next presents nxt_* on AW/W while the response is held.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_start, input int w_start, input int b_lag,
                            input int da, input int dw, input int db, input bit block_next);
        int c = 0, t_aw = -100, t_w = -100, t_b = 0, idx;
        bit aw_done = 0, w_done = 0, b_seen = 0, timed_out = 0;
        logic [1:0] exp_resp;
        exp_resp = model_resp(addr);
        cfg_aw = 5'(da); cfg_w = 5'(dw); cfg_b = 5'(db);
        forever begin
            bus.awvalid = !aw_done && c >= aw_start;
            bus.awaddr  = addr;
            bus.awprot  = 3'($urandom);
            bus.wvalid  = !w_done && c >= w_start;
            bus.wdata   = data;
            bus.wstrb   = strb;
            bus.bready  = b_seen && (c >= t_b + 1 + b_lag);
            if (block_next && b_seen && !bus.bready) begin
                bus.awvalid = 1'b1; bus.awaddr = nxt_addr;
                bus.wvalid  = 1'b1; bus.wdata  = nxt_data; bus.wstrb = nxt_strb;
            end
            @(negedge aclk);
            if (block_next && b_seen && !bus.bready) begin
                check("awready_blocked", bus.awready, 1'b0);
                check("wready_blocked",  bus.wready,  1'b0);
            end
            if (!aw_done && bus.awvalid && bus.awready) begin
                aw_done = 1; t_aw = c;
                check("aw_latency", 64'(c - aw_start), 64'(da));
            end
            if (!w_done && bus.wvalid && bus.wready) begin
                w_done = 1; t_w = c;
                check("w_latency", 64'(c - w_start), 64'(dw));
            end
            if (!b_seen && bus.bvalid) begin
                b_seen = 1; t_b = c;
                check("b_latency", 64'(c - ((t_aw > t_w) ? t_aw : t_w)), 64'(2 + db));
                check("bresp", bus.bresp, exp_resp);
            end else if (b_seen) begin
                check("bvalid_hold", bus.bvalid, 1'b1);
                check("bresp_hold",  bus.bresp,  exp_resp);
                if (bus.bready) break;
            end
            @(posedge aclk); #1;
            c++;
            if (c > 300) begin
                check("write_timeout", 1'b0, 1'b1);
                timed_out = 1;
                break;
            end
        end
        @(posedge aclk); #1;
        idle_bus();
        if (!timed_out) begin
            @(negedge aclk);
            check("bvalid_clear", bus.bvalid, 1'b0);
        end
        @(posedge aclk); #1;
        idx = model_idx(addr);
        if (exp_resp == 2'b00)
            for (int b = 0; b < 4; b++)
                if (strb[b]) mem_model[idx][8*b +: 8] = data[8*b +: 8];
        dbg_addr = 6'(idx);
        #1;
        check("mem_word", dbg_data, mem_model[idx]);
    endtask

    initial begin
        logic [31:0] a;
        int kind;
        idle_bus();
        cfg_aw = '0; cfg_w = '0; cfg_b = '0; dbg_addr = '0;
        nxt_addr = '0; nxt_data = '0; nxt_strb = '0;
        clear_model();
        areset = 1'b1;
        repeat (3) @(posedge aclk);
        #1 areset = 1'b0;

        @(negedge aclk);
        check("rst_awready", bus.awready, 1'b0);
        check("rst_wready",  bus.wready,  1'b0);
        check("rst_bvalid",  bus.bvalid,  1'b0);
        check("rst_bresp",   bus.bresp,   2'b00);
        sweep("rst_mem");
        @(posedge aclk); #1;

        // Basic write, everything same cycle.
        do_write(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 0, 0);
        dbg_addr = 6'd4; #1;
        check("word4", dbg_data, 32'hDEADBEEF);

        // Preload then partial-strobe write with W leading AW by 3 cycles.
        do_write(32'h20, 32'h11223344, 4'hF, 0, 0, 1, 0, 0, 0, 0);
        do_write(32'h20, 32'h0000ABCD, 4'h3, 3, 0, 0, 0, 0, 0, 0);
        dbg_addr = 6'd8; #1;
        check("word8_strobed", dbg_data, 32'h1122ABCD);

        do_write(32'h40, 32'hCAFEF00D, 4'hF, 0, 0, 2, 4, 2, 3, 0);

        // Error responses leave memory untouched.
        do_write(32'h00,  32'hFFFFFFFF, 4'hF, 0, 0, 0, 0, 0, 0, 0);
        do_write(32'h100, 32'hFFFFFFFF, 4'hF, 0, 1, 0, 0, 0, 1, 0);
        do_write(32'h21,  32'hFFFFFFFF, 4'hF, 1, 0, 0, 0, 0, 0, 0);
        dbg_addr = 6'd8; #1;
        check("word8_after_err", dbg_data, 32'h1122ABCD);
        do_write(32'h44, 32'h12345678, 4'h0, 0, 0, 0, 0, 0, 0, 0);

        // Response held 10 cycles while a second write is presented.
        nxt_addr = 32'h80; nxt_data = 32'hA5A55A5A; nxt_strb = 4'hF;
        do_write(32'h7C, 32'h0BADF00D, 4'hF, 0, 0, 10, 0, 0, 0, 1);
        do_write(nxt_addr, nxt_data, nxt_strb, 0, 0, 0, 0, 0, 0, 0);

        // Reset while the response delay is counting down.
        cfg_aw = '0; cfg_w = '0; cfg_b = 5'd10;
        bus.awvalid = 1'b1; bus.awaddr = 32'h30; bus.wvalid = 1'b1;
        bus.wdata = 32'h55AA55AA; bus.wstrb = 4'hF;
        @(negedge aclk);
        check("mid_aw_hs", bus.awready, 1'b1);
        check("mid_w_hs",  bus.wready,  1'b1);
        @(posedge aclk); #1;
        idle_bus();
        repeat (3) @(posedge aclk);
        #1 areset = 1'b1;
        @(posedge aclk);
        #1 areset = 1'b0;
        clear_model();
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            if (bus.bvalid !== 1'b0) check("no_b_after_rst", bus.bvalid, 1'b0);
        end
        check("mid_bvalid",  bus.bvalid,  1'b0);
        check("mid_bresp",   bus.bresp,   2'b00);
        check("mid_awready", bus.awready, 1'b0);
        check("mid_wready",  bus.wready,  1'b0);
        sweep("mid_mem");
        @(posedge aclk); #1;

        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 9);
            if (kind == 0)      a = 32'h100 + 32'($urandom_range(0, 255));
            else if (kind == 1) a = 32'h0;
            else if (kind == 2) a = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
            else                a = {24'h0, 6'($urandom_range(1, 63)), 2'b00};
            do_write(a, $urandom, 4'($urandom), $urandom_range(0, 4), $urandom_range(0, 4),
                     $urandom_range(0, 5), $urandom_range(0, 6), $urandom_range(0, 6),
                     $urandom_range(0, 6), 0);
        end
        sweep("final_mem");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
